bp_bpred_profiler: RTL and testbench
====================================

BP_BPRED_PROFILER -- requirements
Module: bp_bpred_profiler

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_inv_cfg, processor config supplying vaddr_width_p.
REQ-002 SHALL have parameter num_chan_p, default 2, number of independent branch-event channels (1..4).
REQ-003 SHALL have parameter cnt_width_p, default 32, width of every statistic counter (8..64).
REQ-004 SHALL have parameter trace_file_p, default "branch_predict", trace file base name.
REQ-005 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset_i  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port is_br_i  input  num_chan_p  per-channel branch event strobe.
REQ-008 SHALL have port br_target_i  input  num_chan_p*vaddr_width_p  per-channel predicted target, channel c in slice c.
REQ-009 SHALL have port ovr_taken_i  input  num_chan_p  per-channel override-to-taken flag, qualified by is_br_i.
REQ-010 SHALL have port ovr_ntaken_i  input  num_chan_p  per-channel override-to-not-taken flag, qualified by is_br_i.
REQ-011 SHALL have port redirect_i  input  1  backend misprediction redirect strobe.
REQ-012 SHALL have port snap_v_i  input  1  snapshot request pulse.
REQ-013 SHALL have port snap_busy_o  output  1  dump in progress.
REQ-014 SHALL have ports stat_v_o output 1, stat_ready_i input 1, stat_o output cnt_width_p, stat_id_o output $clog2(4*num_chan_p+1): valid/ready statistic stream.

Function
REQ-015 Per channel c SHALL keep live counters br[c], ot[c], ont[c], cf[c]; plus one global live counter rd.
REQ-016 is_br_i[c]=1 SHALL increment br[c]; additionally ot[c] if only ovr_taken_i[c], ont[c] if only ovr_ntaken_i[c], cf[c] (conflict) if both.
REQ-017 ovr_taken_i/ovr_ntaken_i with is_br_i[c]=0 SHALL be ignored; redirect_i=1 SHALL increment rd.
REQ-018 All counters SHALL saturate at 2^cnt_width_p-1, never wrap.
REQ-019 FSM states e_idle, e_dump; snap_busy_o=1 exactly in e_dump.
REQ-020 In e_idle, snap_v_i=1 SHALL copy all live counters into shadow registers, clear live counters, enter e_dump next cycle.
REQ-021 An event coinciding with the capture cycle SHALL be counted in the new window (live counter reads 1, shadow excludes it).
REQ-022 snap_v_i in e_dump SHALL be ignored; live counting continues unaffected during dump.
REQ-023 In e_dump, stat_v_o=1 with entries in order: for c=0..num_chan_p-1: br,ot,ont,cf (ids 4c..4c+3); then rd (id 4*num_chan_p).
REQ-024 Index SHALL advance only on stat_v_o&stat_ready_i; stat_o/stat_id_o SHALL hold stable while stalled.
REQ-025 Handshake on the last entry SHALL return to e_idle next cycle; zero-bubble streaming when stat_ready_i held high (4*num_chan_p+1 cycles).

Reset
REQ-026 reset_i=1 SHALL clear all live and shadow counters, set e_idle, index 0, stat_v_o=0, snap_busy_o=0, stat_o=0, stat_id_o=0.
REQ-027 Reset mid-dump SHALL abort the dump with no further stat_v_o beats; events during reset SHALL not count.

Configuration
REQ-028 Macro BP_BPRED_TRACE_EN defined: simulation-only trace opens "<trace_file_p>.trace" on first cycle after reset deassert, writes one line per is_br_i[c] event: channel, br_target, ovr_taken, ovr_ntaken.
REQ-029 BP_BPRED_TRACE_EN undefined: no file I/O, block fully synthesizable; counting/dump behaviour identical either way.

Verification
REQ-030 num_chan_p=2: 5 branches ch0 (2 ovr_taken, 1 both), 3 ch1 plain, 4 redirects, snapshot, ready=1 -> ids 0..8 = 5,2,0,1,3,0,0,0,4 on consecutive cycles.
REQ-031 snap_v_i with is_br_i[0]=1 same cycle, prior br[0]=7 -> dump br[0]=7; next snapshot br[0]=1.
REQ-032 cnt_width_p=8, 300 ch0 branches, snapshot -> br[0]=255.
REQ-033 stat_ready_i toggled 0/1 each cycle -> 9 beats over ~18 cycles, values stable while stalled, second snap_v_i mid-dump ignored.
REQ-034 reset_i at beat 3 of dump -> stat_v_o=0 next cycle, snap_busy_o=0, subsequent snapshot with no events dumps all zeros.
REQ-035 ovr_taken_i=1 with is_br_i=0 for 10 cycles -> all ch counters 0 after snapshot.

Source files
------------

// File: rtl/bp_bpred_profiler.sv
// bp_bpred_profiler: per-channel branch-override statistics with snapshot and valid/ready dump.
module bp_bpred_profiler #(
  parameter int bp_params_p  = 0,
  parameter int num_chan_p   = 2,
  parameter int cnt_width_p  = 32,
  parameter     trace_file_p = "branch_predict",
  localparam int vaddr_width_p = (bp_params_p == 0) ? 39 : 48,
  localparam int n_stat_lp     = 4 * num_chan_p + 1,
  localparam int id_width_lp   = $clog2(n_stat_lp)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_chan_p-1:0]               is_br_i,
  input  logic [num_chan_p*vaddr_width_p-1:0] br_target_i,
  input  logic [num_chan_p-1:0]               ovr_taken_i,
  input  logic [num_chan_p-1:0]               ovr_ntaken_i,
  input  logic                                redirect_i,
  input  logic                                snap_v_i,
  output logic                                snap_busy_o,
  output logic                                stat_v_o,
  input  logic                                stat_ready_i,
  output logic [cnt_width_p-1:0]              stat_o,
  output logic [id_width_lp-1:0]              stat_id_o
);
  typedef enum logic {e_idle, e_dump} state_e;
  state_e                 r_state, w_state_nxt;
  logic [cnt_width_p-1:0] r_live [n_stat_lp];
  logic [cnt_width_p-1:0] r_shad [n_stat_lp];
  logic [id_width_lp-1:0] r_idx;
  logic                   w_inc [n_stat_lp];
  logic                   w_capture, w_hs, w_last;
  always_comb begin
    for (int c = 0; c < num_chan_p; c++) begin
      w_inc[4*c]   = is_br_i[c];
      w_inc[4*c+1] = is_br_i[c] & ovr_taken_i[c] & ~ovr_ntaken_i[c];
      w_inc[4*c+2] = is_br_i[c] & ~ovr_taken_i[c] & ovr_ntaken_i[c];
      w_inc[4*c+3] = is_br_i[c] & ovr_taken_i[c] & ovr_ntaken_i[c];
    end
    w_inc[n_stat_lp-1] = redirect_i;
  end
  assign w_capture   = (r_state == e_idle) & snap_v_i;
  assign w_hs        = stat_v_o & stat_ready_i;
  assign w_last      = r_idx == id_width_lp'(n_stat_lp - 1);
  assign w_state_nxt = w_capture ? e_dump : (w_hs && w_last) ? e_idle : r_state;
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= e_idle;
    else         r_state <= w_state_nxt;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < n_stat_lp; k++) begin
        r_live[k] <= '0;
        r_shad[k] <= '0;
      end
      r_idx <= '0;
    end else begin
      for (int k = 0; k < n_stat_lp; k++) begin
        if (w_capture) begin
          r_shad[k] <= r_live[k];
          r_live[k] <= cnt_width_p'(w_inc[k]);
        end else if (w_inc[k] && r_live[k] != '1) begin
          r_live[k] <= r_live[k] + cnt_width_p'(1);
        end
      end
      if (w_hs) r_idx <= w_last ? '0 : r_idx + id_width_lp'(1);
    end
  end
  assign stat_v_o    = r_state == e_dump;
  assign snap_busy_o = r_state == e_dump;
  assign stat_o      = stat_v_o ? r_shad[r_idx] : '0;
  assign stat_id_o   = r_idx;
`ifdef BP_BPRED_TRACE_EN
  always_ff @(posedge clk_i) begin
    if (!reset_i)
      for (int c = 0; c < num_chan_p; c++)
        if (is_br_i[c])
          $display("%s %0d %h %b %b", trace_file_p, c, br_target_i[c*vaddr_width_p +: vaddr_width_p],
                   ovr_taken_i[c], ovr_ntaken_i[c]);
  end
`else
  logic w_unused;
  assign w_unused = ^{br_target_i, 32'($bits(trace_file_p))};
`endif
endmodule

// File: tb/tb_bp_bpred_profiler.sv
// tb_bp_bpred_profiler: directed vectors for counting, snapshot capture, dump handshake and reset abort.
module tb_bp_bpred_profiler;
    localparam int NS = 9;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1, redirect_i = 1'b0, snap_v_i = 1'b0, stat_ready_i = 1'b1;
    logic [1:0]  is_br_i = '0, ovr_taken_i = '0, ovr_ntaken_i = '0;
    logic [77:0] br_target_i = '0;
    logic        stat_v_o, snap_busy_o, v8, b8;
    logic [31:0] stat_o;
    logic [3:0]  stat_id_o, id8;
    logic [7:0]  s8;
    int          checks = 0, errors = 0;
    int          beat;

    typedef struct packed {
        int p0, t0, n0, b0, p1, t1, n1, b1, rd;
        logic [0:8][31:0] e;
    } vec_t;
    vec_t        vecs [3];
    logic [31:0] exp_v [NS];

    bp_bpred_profiler dut (
        .clk_i(clk), .reset_i(reset_i), .is_br_i(is_br_i), .br_target_i(br_target_i),
        .ovr_taken_i(ovr_taken_i), .ovr_ntaken_i(ovr_ntaken_i), .redirect_i(redirect_i),
        .snap_v_i(snap_v_i), .snap_busy_o(snap_busy_o), .stat_v_o(stat_v_o),
        .stat_ready_i(stat_ready_i), .stat_o(stat_o), .stat_id_o(stat_id_o)
    );

    bp_bpred_profiler #(.cnt_width_p(8)) dut8 (
        .clk_i(clk), .reset_i(reset_i), .is_br_i(is_br_i), .br_target_i(br_target_i),
        .ovr_taken_i(ovr_taken_i), .ovr_ntaken_i(ovr_ntaken_i), .redirect_i(redirect_i),
        .snap_v_i(snap_v_i), .snap_busy_o(b8), .stat_v_o(v8),
        .stat_ready_i(stat_ready_i), .stat_o(s8), .stat_id_o(id8)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic ev(input int c, input logic t, input logic n, input int cnt);
        repeat (cnt) begin
            is_br_i[c] = 1'b1;
            ovr_taken_i[c] = t;
            ovr_ntaken_i[c] = n;
            tick();
            is_br_i = '0;
            ovr_taken_i = '0;
            ovr_ntaken_i = '0;
        end
    endtask

    task automatic redir(input int cnt);
        repeat (cnt) begin
            redirect_i = 1'b1;
            tick();
            redirect_i = 1'b0;
        end
    endtask

    task automatic snap;
        snap_v_i = 1'b1;
        tick();
        snap_v_i = 1'b0;
    endtask

    task automatic clr_exp;
        for (int k = 0; k < NS; k++) exp_v[k] = '0;
    endtask

    task automatic dump_check(input string nm);
        stat_ready_i = 1'b1;
        chk({nm, " busy"}, snap_busy_o, 1);
        for (int k = 0; k < NS; k++) begin
            chk($sformatf("%s valid%0d", nm, k), stat_v_o, 1);
            chk($sformatf("%s id%0d", nm, k), stat_id_o, k);
            chk($sformatf("%s val%0d", nm, k), stat_o, exp_v[k]);
            tick();
        end
        chk({nm, " end valid"}, stat_v_o, 0);
        chk({nm, " end busy"}, snap_busy_o, 0);
    endtask

    initial begin
        vecs[0] = '{2, 2, 0, 1, 3, 0, 0, 0, 4, {32'd5, 32'd2, 32'd0, 32'd1, 32'd3, 32'd0, 32'd0, 32'd0, 32'd4}};
        vecs[1] = '{0, 0, 0, 0, 0, 1, 2, 1, 0, {32'd0, 32'd0, 32'd0, 32'd0, 32'd4, 32'd1, 32'd2, 32'd1, 32'd0}};
        vecs[2] = '{1, 0, 3, 2, 0, 0, 0, 0, 1, {32'd6, 32'd0, 32'd3, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1}};

        tick();
        tick();
        chk("reset valid", stat_v_o, 0);
        chk("reset busy", snap_busy_o, 0);
        chk("reset stat", stat_o, 0);
        chk("reset id", stat_id_o, 0);
        reset_i = 1'b0;
        tick();

        for (int i = 0; i < 3; i++) begin
            ev(0, 0, 0, vecs[i].p0); ev(0, 1, 0, vecs[i].t0); ev(0, 0, 1, vecs[i].n0); ev(0, 1, 1, vecs[i].b0);
            ev(1, 0, 0, vecs[i].p1); ev(1, 1, 0, vecs[i].t1); ev(1, 0, 1, vecs[i].n1); ev(1, 1, 1, vecs[i].b1);
            redir(vecs[i].rd);
            snap();
            for (int k = 0; k < NS; k++) exp_v[k] = vecs[i].e[k];
            dump_check($sformatf("vec%0d", i));
        end

        // Event in the capture cycle belongs to the next window.
        ev(0, 0, 0, 7);
        snap_v_i = 1'b1;
        is_br_i[0] = 1'b1;
        tick();
        snap_v_i = 1'b0;
        is_br_i = '0;
        clr_exp();
        exp_v[0] = 7;
        dump_check("capture old");
        snap();
        exp_v[0] = 1;
        dump_check("capture new");

        ev(0, 0, 0, 300);
        snap();
        chk("sat8 valid", v8, 1);
        chk("sat8 id", id8, 0);
        chk("sat8 br0", s8, 255);
        exp_v[0] = 300;
        dump_check("sat32");

        ev(0, 0, 0, 2);
        redir(1);
        clr_exp();
        exp_v[0] = 2;
        exp_v[8] = 1;
        snap();
        beat = 0;
        for (int cyc = 0; cyc < 40 && beat < NS; cyc++) begin
            stat_ready_i = cyc[0];
            snap_v_i = (cyc == 3);
            chk($sformatf("stall valid c%0d", cyc), stat_v_o, 1);
            chk($sformatf("stall id c%0d", cyc), stat_id_o, beat);
            chk($sformatf("stall val c%0d", cyc), stat_o, exp_v[beat]);
            tick();
            if (stat_ready_i) beat++;
        end
        snap_v_i = 1'b0;
        stat_ready_i = 1'b1;
        chk("stall beats", beat, NS);
        chk("stall end valid", stat_v_o, 0);
        chk("stall end busy", snap_busy_o, 0);
        clr_exp();
        snap();
        dump_check("after stall");

        ev(1, 0, 0, 1);
        snap();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("abort id%0d", k), stat_id_o, k);
            tick();
        end
        chk("abort id3", stat_id_o, 3);
        reset_i = 1'b1;
        is_br_i[0] = 1'b1;
        redirect_i = 1'b1;
        tick();
        chk("abort valid", stat_v_o, 0);
        chk("abort busy", snap_busy_o, 0);
        chk("abort id", stat_id_o, 0);
        chk("abort stat", stat_o, 0);
        reset_i = 1'b0;
        is_br_i = '0;
        redirect_i = 1'b0;
        tick();
        chk("abort idle valid", stat_v_o, 0);
        snap();
        dump_check("post reset");

        repeat (10) begin
            ovr_taken_i = 2'b11;
            ovr_ntaken_i = 2'b10;
            tick();
        end
        ovr_taken_i = '0;
        ovr_ntaken_i = '0;
        snap();
        dump_check("ovr no br");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
